// File: rtl/lrsc_pkg.sv
// Shared types for the LR/SC reservation table: SC sequencer states, slot view, granule width.
// Latency: n/a (types only).
// Backpressure: n/a.
package lrsc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        CHECK = 3'b010,
        STORE = 3'b100
    } state_t;

    // Granule is zero-extended to 32 bits so the struct is independent of GRANULE_LOG2.
    typedef struct packed {
        logic        valid;
        logic [31:0] granule;
    } resv_t;

    function automatic int granule_w(input int granule_log2);
        return 32 - granule_log2;
    endfunction

endpackage

// File: rtl/lrsc_resv_table_if.sv
// Execute-stage / snoop / writeback bundle between the pipeline (master) and the reservation table (slave).
// Latency: n/a (wiring only).
// Backpressure: hold_o is the table's stall request back to the pipeline.
interface lrsc_resv_table_if #(
    parameter int NUM_HARTS = 2,
    parameter int HW        = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
);
    logic                 stall;
    logic                 lr_i;
    logic                 sc_i;
    logic [HW-1:0]        hart_i;
    logic [31:0]          addr_i;
    logic                 snoop_we_i;
    logic [31:0]          snoop_addr_i;
    logic [HW-1:0]        snoop_hart_i;
    logic                 snoop_ext_i;
    logic                 hold_o;
    logic                 mem_write_enable_o;
    logic                 write_enable_o;
    logic                 result_o;
    logic [NUM_HARTS-1:0] resv_valid_o;

    modport master (
        output stall, lr_i, sc_i, hart_i, addr_i,
        output snoop_we_i, snoop_addr_i, snoop_hart_i, snoop_ext_i,
        input  hold_o, mem_write_enable_o, write_enable_o, result_o, resv_valid_o
    );

    modport slave (
        input  stall, lr_i, sc_i, hart_i, addr_i,
        input  snoop_we_i, snoop_addr_i, snoop_hart_i, snoop_ext_i,
        output hold_o, mem_write_enable_o, write_enable_o, result_o, resv_valid_o
    );

endinterface

// File: rtl/lrsc_resv_slot.sv
// One hart's reservation: valid + granule, optional expiry counter under LRSC_TIMEOUT_EN.
// Latency: set/clear/snoop take effect at the next edge; set has priority over every clear source.
// Backpressure: none; stall only freezes the expiry counter.
module lrsc_resv_slot
    import lrsc_pkg::*;
#(
    parameter int GRANULE_LOG2 = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        set,
    input  logic        clear,
    input  logic        snoop_hit,
    input  logic [31:0] set_addr,
    output resv_t       resv
);

    localparam int GW = granule_w(GRANULE_LOG2);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("lrsc_resv_slot: TIMEOUT must be >= 2");
    end

    logic          valid_q;
    logic [GW-1:0] granule_q;
    logic          expire;

`ifdef LRSC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    // Slot stays valid for the whole cycle in which the counter sits at TIMEOUT.
    assign expire = valid_q && !stall && (cnt_q == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (set) begin
            cnt_q <= '0;
        end else if (valid_q && !stall && (cnt_q != CW'(TIMEOUT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign expire       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            granule_q <= '0;
        end else if (set) begin
            valid_q   <= 1'b1;
            granule_q <= GW'(set_addr >> GRANULE_LOG2);
        end else if (clear || snoop_hit || expire) begin
            valid_q   <= 1'b0;
        end
    end

    assign resv.valid   = valid_q;
    assign resv.granule = 32'(granule_q);

endmodule

// File: rtl/lrsc_resv_table.sv
// Multi-hart LR/SC reservation table and SC.W sequencer (optional expiry: LRSC_TIMEOUT_EN).
// Latency: sc_i in cycle 0 -> write strobes in cycle 2; LR/snoop update slots at the next edge.
// Backpressure: hold_o stalls the pipeline from SC request through CHECK; stall freezes the FSM.
module lrsc_resv_table
    import lrsc_pkg::*;
#(
    parameter int NUM_HARTS    = 2,
    parameter int GRANULE_LOG2 = 2,
    parameter int TIMEOUT      = 64
) (
    input logic               clk,
    input logic               reset_n,
    lrsc_resv_table_if.slave  bus
);

    localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    resv_t                slot_resv [NUM_HARTS];
    logic [NUM_HARTS-1:0] snoop_hit;
    logic [NUM_HARTS-1:0] slot_set;
    logic [NUM_HARTS-1:0] slot_clear;
    logic [31:0]          req_gran;
    logic [31:0]          snoop_gran;
    resv_t                sel_resv;
    logic                 sel_snoop;
    logic                 sc_ok;
    state_t               state_q, state_n;
    logic                 result_q, result_n;

    assign req_gran   = bus.addr_i >> GRANULE_LOG2;
    assign snoop_gran = bus.snoop_addr_i >> GRANULE_LOG2;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_slot
        // A hart's own store never breaks its own reservation; external masters always do.
        assign snoop_hit[h] = bus.snoop_we_i && slot_resv[h].valid
                            && (slot_resv[h].granule == snoop_gran)
                            && (bus.snoop_ext_i || (bus.snoop_hart_i != HW'(h)));
        assign slot_set[h]  = bus.lr_i && (bus.hart_i == HW'(h));

        lrsc_resv_slot #(
            .GRANULE_LOG2 (GRANULE_LOG2),
            .TIMEOUT      (TIMEOUT)
        ) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .stall     (bus.stall),
            .set       (slot_set[h]),
            .clear     (slot_clear[h]),
            .snoop_hit (snoop_hit[h]),
            .set_addr  (bus.addr_i),
            .resv      (slot_resv[h])
        );

        assign bus.resv_valid_o[h] = slot_resv[h].valid;
    end

    always_comb begin
        sel_resv  = slot_resv[0];
        sel_snoop = snoop_hit[0];
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (bus.hart_i == HW'(h)) begin
                sel_resv  = slot_resv[h];
                sel_snoop = snoop_hit[h];
            end
        end
    end

    assign sc_ok = sel_resv.valid && (sel_resv.granule == req_gran) && !sel_snoop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            result_q <= result_n;
        end
    end

    always_comb begin
        state_n                = state_q;
        result_n               = result_q;
        slot_clear             = '0;
        bus.hold_o             = 1'b0;
        bus.mem_write_enable_o = 1'b0;
        bus.write_enable_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.hold_o = bus.sc_i;
                if (bus.sc_i && !bus.stall) state_n = CHECK;
            end
            CHECK: begin
                bus.hold_o = 1'b1;
                if (!bus.stall) begin
                    // Reservation is consumed even when the SC is flushed here.
                    for (int h = 0; h < NUM_HARTS; h++) slot_clear[h] = (bus.hart_i == HW'(h));
                    if (bus.sc_i) begin
                        result_n = !sc_ok;
                        state_n  = STORE;
                    end else begin
                        state_n  = IDLE;
                    end
                end
            end
            STORE: begin
                // Strobes fire once, on the cycle the FSM actually leaves STORE.
                if (!bus.stall) begin
                    bus.mem_write_enable_o = !result_q;
                    bus.write_enable_o     = 1'b1;
                    state_n                = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.result_o = result_q;

    a_no_lr_while_busy: assert property (@(posedge clk) disable iff (!reset_n)
        bus.lr_i |-> (state_q == IDLE));

endmodule
